// File: rtl/branch_fetch_ctrl.sv
// IF-stage PC generator with a direct-mapped BTB (2-bit counters) and EX-stage
// branch resolution: mispredict detection, PC redirect and IF/ID + ID/EX flush.
module branch_fetch_ctrl #(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
   parameter int              BTB_ENTRIES = 16,
   localparam int             IDX_W       = $clog2(BTB_ENTRIES)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_i,
   input  logic            ex_valid_i,
   input  logic            ex_is_branch_i,
   input  logic            ex_taken_i,
   input  logic [XLEN-1:0] ex_pc_i,
   input  logic [XLEN-1:0] ex_target_i,
   input  logic            ex_pred_taken_i,
   input  logic [XLEN-1:0] ex_pred_target_i,
   output logic [XLEN-1:0] if_pc_o,
   output logic            if_pred_taken_o,
   output logic [XLEN-1:0] if_pred_target_o,
   output logic            flush_ifid_o,
   output logic            flush_idex_o,
   output logic [15:0]     mispred_cnt_o
);

   localparam int              TAG_W   = XLEN - IDX_W - 2;
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

   function automatic logic [1:0] ctr_inc(input logic [1:0] c);
      return (c == 2'b11) ? 2'b11 : c + 2'b01;
   endfunction

   function automatic logic [1:0] ctr_dec(input logic [1:0] c);
      return (c == 2'b00) ? 2'b00 : c - 2'b01;
   endfunction

   logic             btb_valid_r  [BTB_ENTRIES];
   logic [TAG_W-1:0] btb_tag_r    [BTB_ENTRIES];
   logic [XLEN-1:0]  btb_target_r [BTB_ENTRIES];
   logic [1:0]       btb_ctr_r    [BTB_ENTRIES];

   logic [XLEN-1:0]  pc_r;
   logic [XLEN-1:0]  pc_next_s;
   logic [15:0]      mispred_cnt_r;

   logic [IDX_W-1:0] if_idx_s;
   logic             if_hit_s;
   logic             pred_taken_s;
   logic [XLEN-1:0]  pred_target_s;

   logic [IDX_W-1:0] ex_idx_s;
   logic [TAG_W-1:0] ex_tag_s;
   logic             ex_hit_s;
   logic [XLEN-1:0]  ex_next_s;
   logic             mispredict_s;

   logic             upd_we_s;
   logic [1:0]       upd_ctr_s;
   logic [XLEN-1:0]  upd_target_s;

   // BTB lookup on the current fetch PC
   always_comb begin
      if_idx_s      = pc_r[IDX_W+1:2];
      if_hit_s      = btb_valid_r[if_idx_s] && (btb_tag_r[if_idx_s] == pc_r[XLEN-1:IDX_W+2]);
      pred_taken_s  = if_hit_s & btb_ctr_r[if_idx_s][1];
      pred_target_s = if_hit_s ? btb_target_r[if_idx_s] : {XLEN{1'b0}};
   end

   // EX resolution: actual next PC and mispredict detection
   always_comb begin
      ex_idx_s     = ex_pc_i[IDX_W+1:2];
      ex_tag_s     = ex_pc_i[XLEN-1:IDX_W+2];
      ex_hit_s     = btb_valid_r[ex_idx_s] && (btb_tag_r[ex_idx_s] == ex_tag_s);
      ex_next_s    = ex_taken_i ? ex_target_i : ex_pc_i + PC_STEP;
      mispredict_s = ex_valid_i & ((ex_taken_i != ex_pred_taken_i) |
                                   (ex_taken_i & (ex_pred_target_i != ex_target_i)));
   end

   // Next fetch PC; a redirect wins over a hazard stall
   always_comb begin
      pc_next_s = pc_r;
      if (mispredict_s) begin
         pc_next_s = ex_next_s;
      end else if (stall_i) begin
         pc_next_s = pc_r;
      end else if (pred_taken_s) begin
         pc_next_s = pred_target_s;
      end else begin
         pc_next_s = pc_r + PC_STEP;
      end
   end

   // BTB training decision for the resolved EX instruction
   always_comb begin
      upd_we_s     = 1'b0;
      upd_ctr_s    = btb_ctr_r[ex_idx_s];
      upd_target_s = btb_target_r[ex_idx_s];
      if (ex_valid_i) begin
         case ({ex_hit_s, ex_taken_i})
            2'b11: begin
               upd_we_s     = 1'b1;
               upd_ctr_s    = ex_is_branch_i ? ctr_inc(btb_ctr_r[ex_idx_s]) : 2'b11;
               upd_target_s = ex_target_i;
            end
            2'b10: begin
               upd_we_s  = 1'b1;
               upd_ctr_s = ex_is_branch_i ? ctr_dec(btb_ctr_r[ex_idx_s]) : 2'b11;
            end
            2'b01: begin
               // New entries start weakly taken for branches, strongly for jumps
               upd_we_s     = 1'b1;
               upd_ctr_s    = ex_is_branch_i ? 2'b10 : 2'b11;
               upd_target_s = ex_target_i;
            end
            default: begin
               upd_we_s = 1'b0;
            end
         endcase
      end else begin
         upd_we_s = 1'b0;
      end
   end

   // Fetch PC register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r <= RESET_PC;
      end else begin
         pc_r <= pc_next_s;
      end
   end

   // BTB storage; the lookup above always sees pre-edge contents
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_valid_r[i]  <= 1'b0;
            btb_tag_r[i]    <= {TAG_W{1'b0}};
            btb_target_r[i] <= {XLEN{1'b0}};
            btb_ctr_r[i]    <= 2'b01;
         end
      end else if (upd_we_s) begin
         btb_valid_r[ex_idx_s]  <= 1'b1;
         btb_tag_r[ex_idx_s]    <= ex_tag_s;
         btb_target_r[ex_idx_s] <= upd_target_s;
         btb_ctr_r[ex_idx_s]    <= upd_ctr_s;
      end
   end

   // Mispredict event counter, free-running wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mispred_cnt_r <= 16'd0;
      end else if (mispredict_s) begin
         mispred_cnt_r <= mispred_cnt_r + 16'd1;
      end
   end

   assign if_pc_o          = pc_r;
   assign if_pred_taken_o  = pred_taken_s;
   assign if_pred_target_o = pred_target_s;
   assign flush_ifid_o     = mispredict_s & rst_n;
   assign flush_idex_o     = mispredict_s & rst_n;
   assign mispred_cnt_o    = mispred_cnt_r;

endmodule
